mmio_responder: RTL and testbench
=================================

MMIO_RESPONDER -- requirements
Module: mmio_responder

Interface
REQ-001 SHALL have parameter GNT_WAIT, default 0, meaning the number of cycles req_i is held high before gnt_o asserts (0..15).
REQ-002 SHALL have port clk_i  in  1  single clock, rising edge.
REQ-003 SHALL have port rstn_i  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port data_req_i  in  1  initiator request.
REQ-005 SHALL have port data_addr_i  in  32  byte address; only bits [4:2] are decoded.
REQ-006 SHALL have port data_we_i  in  1  1=write, 0=read.
REQ-007 SHALL have port data_be_i  in  4  byte enables.
REQ-008 SHALL have port data_wdata_i  in  32  write data.
REQ-009 SHALL have port data_gnt_o  out  1  request accepted.
REQ-010 SHALL have port data_rvalid_o  out  1  response valid.
REQ-011 SHALL have port data_rdata_o  out  32  read data.
REQ-012 SHALL have port exit_valid_o  out  1  one-cycle exit pulse.
REQ-013 SHALL have port exit_value_o  out  32  exit code.
REQ-014 SHALL have port char_valid_o  out  1  one-cycle console pulse.
REQ-015 SHALL have port char_o  out  8  console character.
REQ-016 SHALL have port irq_o  out  1  level timer interrupt.

Function
REQ-017 SHALL decode the register map on addr[4:2]:
- 0 = EXIT (RW)
- 1 = CONSOLE (WO, reads 0)
- 2 = TIMER (RW)
- 3 = TIMECMP (RW)
- 4 = CTRL (bit0 EN RW, bit1 PEND W1C)
- 5..7 = unmapped: reads 0, writes ignored, handshake still completed.
REQ-018 SHALL use a wait counter: it increments while data_req_i=1 and gnt is not yet given; gnt_o=1 in the cycle where the count equals GNT_WAIT; the counter clears on gnt or when req drops.
REQ-019 With GNT_WAIT=0, gnt_o SHALL be combinationally equal to data_req_i.
REQ-020 The transaction SHALL take effect at the clock edge where req&gnt=1; data_rvalid_o SHALL be 1 in exactly the next cycle.
REQ-021 Back-to-back transactions SHALL be supported: a new gnt may coincide with the previous rvalid, giving one transaction per cycle at GNT_WAIT=0.
REQ-022 For reads, data_rdata_o SHALL carry the register value sampled at the grant edge; for writes, rdata SHALL be 0; outside rvalid, rdata SHALL be 0.
REQ-023 Writes to TIMER, TIMECMP, EXIT and CTRL SHALL honour data_be_i per byte.
- A CONSOLE write SHALL occur only if be[0]=1.
- An EXIT write SHALL pulse only if any be bit is set.
REQ-024 An EXIT write SHALL register exit_value_o and pulse exit_valid_o for one cycle in the cycle after the grant edge; exit_value_o SHALL hold until the next EXIT write.
REQ-025 A CONSOLE write SHALL register char_o=wdata[7:0] and pulse char_valid_o for one cycle after the grant edge.
REQ-026 When EN=1, TIMER SHALL increment by 1 every cycle, wrapping 0xFFFFFFFF to 0 with no flag.
REQ-027 On a simultaneous TIMER write and increment, the written value SHALL win (no increment that cycle).
REQ-028 PEND SHALL set when EN=1 and TIMER==TIMECMP; it SHALL be sticky until a write of 1 to CTRL bit1.
REQ-029 On a simultaneous set and W1C of PEND, set SHALL win.
REQ-030 irq_o SHALL equal the registered PEND bit.

Reset
REQ-031 On rstn_i=0, the block SHALL asynchronously clear:
- outputs: gnt (when GNT_WAIT>0), rvalid, rdata, exit_valid, exit_value, char_valid, char, irq
- state: TIMER, CTRL, wait counter, pending-response flag.
REQ-032 On reset, TIMECMP SHALL be set to 0xFFFFFFFF.
REQ-033 A reset asserted mid-transaction SHALL drop any pending rvalid; no response SHALL follow reset release.

Structure
REQ-034 The register index enum, CTRL bit positions and the TIMECMP reset value SHALL reside in package mmio_pkg.
REQ-035 The timer (TIMER, TIMECMP, EN, PEND, increment/compare/W1C logic) SHALL be a single sub-module, mmio_timer; bus decode and handshake SHALL stay in mmio_responder.

Verification
REQ-036 GNT_WAIT=0: read TIMER after reset with EN=0 -> gnt in the same cycle as req, rvalid next cycle, rdata=0.
REQ-037 GNT_WAIT=3: req held high -> gnt in the 4th req cycle, rvalid in the 5th, and only one transaction is committed.
REQ-038 Write EXIT=0x2A, be=4'b1111 -> exit_valid_o pulses 1 cycle with exit_value_o=0x2A; a read of EXIT returns 0x2A.
REQ-039 Write TIMER=0xFFFFFFFE, TIMECMP=0x1, CTRL=1 -> TIMER wraps to 0; irq_o rises the cycle after TIMER==1; W1C to CTRL bit1 clears irq_o.
REQ-040 Write TIMECMP with be=4'b0010, wdata=0x0000AB00 -> TIMECMP=0xFFFFABFF; back-to-back write then read, each returns rvalid on consecutive cycles.
REQ-041 Assert rstn_i the cycle after a grant -> no rvalid is ever seen for that transaction, and all outputs read 0.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO responder: register map index, CTRL bit
// positions, TIMECMP reset value and a byte-enable merge helper.
package mmio_pkg;

  typedef enum logic [2:0] {
    REG_EXIT    = 3'd0,
    REG_CONSOLE = 3'd1,
    REG_TIMER   = 3'd2,
    REG_TIMECMP = 3'd3,
    REG_CTRL    = 3'd4,
    REG_RSVD5   = 3'd5,
    REG_RSVD6   = 3'd6,
    REG_RSVD7   = 3'd7
  } reg_idx_e;

  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_PEND_BIT = 1;

  localparam logic [31:0] TIMECMP_RST = 32'hFFFF_FFFF;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mmio_responder_if.sv
// Request/grant/response bus bundle between an initiator and mmio_responder.
interface mmio_responder_if;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;

  modport master (
    output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o
  );

  modport slave (
    input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o
  );
endinterface

// File: rtl/mmio_timer.sv
// Free-running timer with compare match: TIMER, TIMECMP, CTRL.EN and the
// sticky CTRL.PEND flag that drives the interrupt.
module mmio_timer
  import mmio_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        wr_timer_i,
  input  logic        wr_timecmp_i,
  input  logic        wr_ctrl_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic [31:0] timer_o,
  output logic [31:0] timecmp_o,
  output logic        en_o,
  output logic        pend_o
);

  logic [31:0] timer_q, timer_d;
  logic [31:0] timecmp_q, timecmp_d;
  logic        en_q, en_d;
  logic        pend_q, pend_d;

  always_comb begin
    timer_d   = timer_q;
    timecmp_d = timecmp_q;
    en_d      = en_q;
    pend_d    = pend_q;

    // A bus write to TIMER replaces that cycle's increment
    if (wr_timer_i) begin
      timer_d = be_merge(timer_q, wdata_i, be_i);
    end else if (en_q) begin
      timer_d = timer_q + 32'd1;
    end

    if (wr_timecmp_i) timecmp_d = be_merge(timecmp_q, wdata_i, be_i);

    if (wr_ctrl_i && be_i[0]) begin
      en_d = wdata_i[CTRL_EN_BIT];
      if (wdata_i[CTRL_PEND_BIT]) pend_d = 1'b0;
    end

    // Compare match is applied last so a coincident W1C loses
    if (en_q && (timer_q == timecmp_q)) pend_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      timer_q   <= '0;
      timecmp_q <= TIMECMP_RST;
      en_q      <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      timecmp_q <= timecmp_d;
      en_q      <= en_d;
      pend_q    <= pend_d;
    end
  end

  assign timer_o   = timer_q;
  assign timecmp_o = timecmp_q;
  assign en_o      = en_q;
  assign pend_o    = pend_q;

endmodule

// File: rtl/mmio_responder.sv
// Simple MMIO target: grant wait counter, register decode, exit/console
// side-channel pulses and a timer with level interrupt.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter int unsigned GNT_WAIT = 0
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o,
  output logic        char_valid_o,
  output logic [7:0]  char_o,
  output logic        irq_o
);

  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        exit_valid_q, exit_valid_d;
  logic [31:0] exit_value_q, exit_value_d;
  logic        char_valid_q, char_valid_d;
  logic [7:0]  char_q, char_d;

  logic        gnt;
  logic        wr;
  reg_idx_e    idx;
  logic [31:0] rd_val;
  logic        wr_timer, wr_timecmp, wr_ctrl;
  logic [31:0] timer, timecmp;
  logic        tmr_en, tmr_pend;
  logic        unused_addr;

  assign idx         = reg_idx_e'(data_addr_i[4:2]);
  assign unused_addr = ^{data_addr_i[31:5], data_addr_i[1:0]};

  // With GNT_WAIT=0 the counter never leaves zero, so gnt follows req directly
  assign gnt = data_req_i && (wait_cnt_q == 4'(GNT_WAIT));
  assign wr  = gnt && data_we_i;

  assign wr_timer   = wr && (idx == REG_TIMER);
  assign wr_timecmp = wr && (idx == REG_TIMECMP);
  assign wr_ctrl    = wr && (idx == REG_CTRL);

  always_comb begin
    rd_val = '0;
    case (idx)
      REG_EXIT:    rd_val = exit_value_q;
      REG_TIMER:   rd_val = timer;
      REG_TIMECMP: rd_val = timecmp;
      REG_CTRL:    rd_val = {30'd0, tmr_pend, tmr_en};
      default:     rd_val = '0;
    endcase
  end

  always_comb begin
    wait_cnt_d   = (data_req_i && !gnt) ? wait_cnt_q + 4'd1 : '0;
    rvalid_d     = gnt;
    rdata_d      = (gnt && !data_we_i) ? rd_val : '0;
    exit_valid_d = wr && (idx == REG_EXIT) && (|data_be_i);
    exit_value_d = exit_valid_d ? be_merge(exit_value_q, data_wdata_i, data_be_i)
                                : exit_value_q;
    char_valid_d = wr && (idx == REG_CONSOLE) && data_be_i[0];
    char_d       = char_valid_d ? data_wdata_i[7:0] : char_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wait_cnt_q   <= '0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      exit_valid_q <= 1'b0;
      exit_value_q <= '0;
      char_valid_q <= 1'b0;
      char_q       <= '0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      exit_valid_q <= exit_valid_d;
      exit_value_q <= exit_value_d;
      char_valid_q <= char_valid_d;
      char_q       <= char_d;
    end
  end

  mmio_timer u_timer (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .wr_timer_i   (wr_timer),
    .wr_timecmp_i (wr_timecmp),
    .wr_ctrl_i    (wr_ctrl),
    .wdata_i      (data_wdata_i),
    .be_i         (data_be_i),
    .timer_o      (timer),
    .timecmp_o    (timecmp),
    .en_o         (tmr_en),
    .pend_o       (tmr_pend)
  );

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign exit_valid_o  = exit_valid_q;
  assign exit_value_o  = exit_value_q;
  assign char_valid_o  = char_valid_q;
  assign char_o        = char_q;
  assign irq_o         = tmr_pend;

endmodule

// File: tb/tb_mmio_responder.sv
// Scoreboard bench for mmio_responder: one instance with GNT_WAIT=0 for the
// register map and timer, one with GNT_WAIT=3 for grant latency.
module tb_mmio_responder;
  import mmio_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mmio_responder_if bus_a ();
  mmio_responder_if bus_b ();

  logic        exit_valid_a, char_valid_a, irq_a;
  logic [31:0] exit_value_a;
  logic [7:0]  char_a;
  logic        exit_valid_b, char_valid_b, irq_b;
  logic [31:0] exit_value_b;
  logic [7:0]  char_b;

  mmio_responder #(.GNT_WAIT(0)) dut_a (
    .clk_i(clk), .rstn_i(rstn),
    .data_req_i(bus_a.data_req_i), .data_addr_i(bus_a.data_addr_i),
    .data_we_i(bus_a.data_we_i), .data_be_i(bus_a.data_be_i),
    .data_wdata_i(bus_a.data_wdata_i), .data_gnt_o(bus_a.data_gnt_o),
    .data_rvalid_o(bus_a.data_rvalid_o), .data_rdata_o(bus_a.data_rdata_o),
    .exit_valid_o(exit_valid_a), .exit_value_o(exit_value_a),
    .char_valid_o(char_valid_a), .char_o(char_a), .irq_o(irq_a)
  );

  mmio_responder #(.GNT_WAIT(3)) dut_b (
    .clk_i(clk), .rstn_i(rstn),
    .data_req_i(bus_b.data_req_i), .data_addr_i(bus_b.data_addr_i),
    .data_we_i(bus_b.data_we_i), .data_be_i(bus_b.data_be_i),
    .data_wdata_i(bus_b.data_wdata_i), .data_gnt_o(bus_b.data_gnt_o),
    .data_rvalid_o(bus_b.data_rvalid_o), .data_rdata_o(bus_b.data_rdata_o),
    .exit_valid_o(exit_valid_b), .exit_value_o(exit_value_b),
    .char_valid_o(char_valid_b), .char_o(char_b), .irq_o(irq_b)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic        mon_en = 1'b0;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic        exp_rv_a = 1'b0;
  logic        exp_rv_b = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitors: rvalid must follow each grant by exactly one cycle
  always @(negedge clk) begin
    if (mon_en) begin
      check("rvalid_a", 32'(bus_a.data_rvalid_o), 32'(exp_rv_a && rstn));
      if (bus_a.data_rvalid_o) begin
        if (q_a.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rsp_a: got unexpected response %h expected none", bus_a.data_rdata_o);
        end else check("rdata_a", bus_a.data_rdata_o, q_a.pop_front());
      end else check("rdata_idle_a", bus_a.data_rdata_o, 32'd0);
    end
    exp_rv_a <= bus_a.data_req_i && bus_a.data_gnt_o && rstn;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("rvalid_b", 32'(bus_b.data_rvalid_o), 32'(exp_rv_b && rstn));
      if (bus_b.data_rvalid_o) begin
        if (q_b.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rsp_b: got unexpected response %h expected none", bus_b.data_rdata_o);
        end else check("rdata_b", bus_b.data_rdata_o, q_b.pop_front());
      end else check("rdata_idle_b", bus_b.data_rdata_o, 32'd0);
    end
    exp_rv_b <= bus_b.data_req_i && bus_b.data_gnt_o && rstn;
  end

  task automatic idle_a(input int unsigned cycles);
    bus_a.data_req_i   = 1'b0;
    bus_a.data_we_i    = 1'b0;
    bus_a.data_addr_i  = '0;
    bus_a.data_be_i    = '0;
    bus_a.data_wdata_i = '0;
    repeat (cycles) begin
      @(posedge clk); #1;
    end
  endtask

  // Leaves req asserted so consecutive calls form back-to-back transfers
  task automatic issue_a(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] exp);
    bus_a.data_req_i   = 1'b1;
    bus_a.data_we_i    = we;
    bus_a.data_addr_i  = addr;
    bus_a.data_be_i    = be;
    bus_a.data_wdata_i = wd;
    q_a.push_back(exp);
    @(negedge clk);
    check("gnt_a", 32'(bus_a.data_gnt_o), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rvalid"}, 32'(bus_a.data_rvalid_o), 32'd0);
    check({tag, "_rdata"}, bus_a.data_rdata_o, 32'd0);
    check({tag, "_exit_valid"}, 32'(exit_valid_a), 32'd0);
    check({tag, "_exit_value"}, exit_value_a, 32'd0);
    check({tag, "_char_valid"}, 32'(char_valid_a), 32'd0);
    check({tag, "_char"}, 32'(char_a), 32'd0);
    check({tag, "_irq"}, 32'(irq_a), 32'd0);
    check({tag, "_gnt_b"}, 32'(bus_b.data_gnt_o), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_b.data_req_i = 1'b0; bus_b.data_we_i = 1'b0; bus_b.data_addr_i = '0;
    bus_b.data_be_i = '0; bus_b.data_wdata_i = '0;
    idle_a(2);
    check_reset_outputs("reset");
    rstn   = 1'b1;
    mon_en = 1'b1;
    idle_a(1);

    // GNT_WAIT=3: an aborted request must restart the count
    bus_b.data_req_i = 1'b1; bus_b.data_addr_i = 32'hC;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); check("gnt_b_abort", 32'(bus_b.data_gnt_o), 32'd0);
      @(posedge clk); #1;
    end
    bus_b.data_req_i = 1'b0;
    @(posedge clk); #1;
    bus_b.data_req_i = 1'b1;
    q_b.push_back(32'hFFFF_FFFF);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); check("gnt_b_wait", 32'(bus_b.data_gnt_o), 32'(i == 4));
      @(posedge clk); #1;
    end
    bus_b.data_req_i = 1'b0;
    idle_a(3);

    // Reads after reset
    issue_a(1'b0, 32'h08, 4'hF, 32'd0, 32'd0);
    issue_a(1'b0, 32'h0C, 4'hF, 32'd0, 32'hFFFF_FFFF);
    issue_a(1'b0, 32'h10, 4'hF, 32'd0, 32'd0);
    idle_a(1);

    // EXIT pulse, hold and byte enables
    issue_a(1'b1, 32'h00, 4'hF, 32'h2A, 32'd0);
    idle_a(0);
    check("exit_pulse", 32'(exit_valid_a), 32'd1);
    check("exit_value", exit_value_a, 32'h2A);
    idle_a(1);
    check("exit_pulse_end", 32'(exit_valid_a), 32'd0);
    check("exit_hold", exit_value_a, 32'h2A);
    issue_a(1'b0, 32'h00, 4'hF, 32'd0, 32'h2A);
    issue_a(1'b1, 32'h00, 4'h0, 32'h5, 32'd0);
    idle_a(0);
    check("exit_be0_nopulse", 32'(exit_valid_a), 32'd0);
    check("exit_be0_value", exit_value_a, 32'h2A);
    issue_a(1'b1, 32'h00, 4'h1, 32'h1122_3344, 32'd0);
    idle_a(0);
    check("exit_be1_pulse", 32'(exit_valid_a), 32'd1);
    check("exit_be1_value", exit_value_a, 32'h44);
    issue_a(1'b0, 32'h100, 4'hF, 32'd0, 32'h44);

    // CONSOLE, unmapped slots
    issue_a(1'b1, 32'h04, 4'h1, 32'h141, 32'd0);
    idle_a(0);
    check("char_pulse", 32'(char_valid_a), 32'd1);
    check("char_value", 32'(char_a), 32'h41);
    idle_a(1);
    check("char_pulse_end", 32'(char_valid_a), 32'd0);
    issue_a(1'b1, 32'h04, 4'hE, 32'h55, 32'd0);
    idle_a(0);
    check("char_be_nopulse", 32'(char_valid_a), 32'd0);
    check("char_hold", 32'(char_a), 32'h41);
    issue_a(1'b0, 32'h04, 4'hF, 32'd0, 32'd0);
    issue_a(1'b1, 32'h14, 4'hF, 32'hDEAD_BEEF, 32'd0);
    issue_a(1'b0, 32'h14, 4'hF, 32'd0, 32'd0);
    issue_a(1'b0, 32'h1C, 4'hF, 32'd0, 32'd0);

    // TIMECMP byte write, back-to-back with its read
    issue_a(1'b1, 32'h0C, 4'b0010, 32'h0000_AB00, 32'd0);
    issue_a(1'b0, 32'h0C, 4'hF, 32'd0, 32'hFFFF_ABFF);
    idle_a(1);

    // Timer wrap, compare match and W1C
    issue_a(1'b1, 32'h0C, 4'hF, 32'h1, 32'd0);
    issue_a(1'b1, 32'h08, 4'hF, 32'hFFFF_FFFE, 32'd0);
    issue_a(1'b1, 32'h10, 4'hF, 32'h1, 32'd0);
    issue_a(1'b0, 32'h08, 4'hF, 32'd0, 32'hFFFF_FFFE);
    check("irq_pre0", 32'(irq_a), 32'd0);
    issue_a(1'b0, 32'h08, 4'hF, 32'd0, 32'hFFFF_FFFF);
    check("irq_pre1", 32'(irq_a), 32'd0);
    issue_a(1'b0, 32'h08, 4'hF, 32'd0, 32'h0);
    check("irq_pre2", 32'(irq_a), 32'd0);
    issue_a(1'b0, 32'h08, 4'hF, 32'd0, 32'h1);
    check("irq_rise", 32'(irq_a), 32'd1);
    idle_a(2);
    check("irq_sticky", 32'(irq_a), 32'd1);
    issue_a(1'b0, 32'h10, 4'hF, 32'd0, 32'h3);
    issue_a(1'b1, 32'h10, 4'h1, 32'h3, 32'd0);
    check("irq_w1c", 32'(irq_a), 32'd0);
    issue_a(1'b0, 32'h10, 4'hF, 32'd0, 32'h1);
    issue_a(1'b1, 32'h10, 4'hF, 32'h0, 32'd0);
    issue_a(1'b0, 32'h10, 4'hF, 32'd0, 32'h0);
    idle_a(1);

    // Reset between grant and response: the response must never appear
    bus_a.data_req_i = 1'b1; bus_a.data_we_i = 1'b1; bus_a.data_addr_i = 32'h0;
    bus_a.data_be_i = 4'hF; bus_a.data_wdata_i = 32'h77;
    @(negedge clk);
    check("gnt_before_rst", 32'(bus_a.data_gnt_o), 32'd1);
    #2 rstn = 1'b0;
    idle_a(2);
    check_reset_outputs("midrst");
    rstn = 1'b1;
    idle_a(3);
    check_reset_outputs("postrst");
    issue_a(1'b0, 32'h00, 4'hF, 32'd0, 32'd0);
    issue_a(1'b0, 32'h0C, 4'hF, 32'd0, 32'hFFFF_FFFF);
    issue_a(1'b0, 32'h08, 4'hF, 32'd0, 32'd0);
    idle_a(3);

    check("q_a_drained", 32'(q_a.size()), 32'd0);
    check("q_b_drained", 32'(q_b.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
